// File: rtl/ram_sp_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ram_sp_arbiter_pkg: shared types, constants and round-robin pick |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package ram_sp_arbiter_pkg;

    localparam int MAX_REQ     = 4;
    localparam int IDX_W       = 2;
    localparam int STALL_CNT_W = 16;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] index;
    } tag_t;

    // Returns {found, index}. Lowest offset from ptr wins, so scan backwards.
    function automatic logic [IDX_W:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr,
                                               input int                 n);
        logic [IDX_W:0] res;
        int             idx;
        res = '0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = (int'(ptr) + k) % n;
                if (req[idx[IDX_W-1:0]]) begin
                    res = {1'b1, idx[IDX_W-1:0]};
                end
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_sp_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ram_sp_arbiter_if: requester bus and RAM port bundle             |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface ram_sp_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int width_a    = 32,
    parameter int widthad_a  = 10,
    parameter int width_be_a = 4
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_write;
    logic [NUM_REQ*widthad_a-1:0]  req_addr;
    logic [NUM_REQ*width_a-1:0]    req_wdata;
    logic [NUM_REQ*width_be_a-1:0] req_be;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [width_a-1:0]            rsp_data;
    logic                          ram_clken;
    logic                          ram_read_en;
    logic                          ram_write_en;
    logic [widthad_a-1:0]          ram_address;
    logic [width_be_a-1:0]         ram_byte_en;
    logic [width_a-1:0]            ram_write_data;
    logic [width_a-1:0]            ram_read_data;

    // master is the environment: requesters plus the RAM read-data return
    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, ram_read_data,
        input  req_ready, rsp_valid, rsp_data, ram_clken, ram_read_en,
               ram_write_en, ram_address, ram_byte_en, ram_write_data
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, ram_read_data,
        output req_ready, rsp_valid, rsp_data, ram_clken, ram_read_en,
               ram_write_en, ram_address, ram_byte_en, ram_write_data
    );
endinterface
`default_nettype wire

// File: rtl/ram_sp_arbiter_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_arbiter: combinational round-robin grant with pointer reg     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module rr_arbiter
    import ram_sp_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] i_req,
    output logic [NUM_REQ-1:0] o_grant,
    output logic               o_any,
    output logic [IDX_W-1:0]   o_winner
);
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W:0]     w_pick;
    logic [MAX_REQ-1:0] w_req_ext;

    assign w_req_ext = MAX_REQ'(i_req);
    assign w_pick    = rr_pick(w_req_ext, r_rr_ptr, NUM_REQ);
    assign o_any     = w_pick[IDX_W] & ~reset;
    assign o_winner  = w_pick[IDX_W-1:0];

    always_comb begin
        o_grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            o_grant[i] = o_any && (int'(o_winner) == i);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr <= '0;
        end else if (o_any) begin
            r_rr_ptr <= IDX_W'((int'(o_winner) + 1) % NUM_REQ);
        end
    end
endmodule
`default_nettype wire

// File: rtl/ram_sp_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ram_sp_arbiter: N-way round-robin access to one single-port RAM  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module ram_sp_arbiter
    import ram_sp_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int width_a    = 32,
    parameter int widthad_a  = 10,
    parameter int width_be_a = 4,
    parameter int latency    = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    ram_sp_arbiter_if.slave        bus,
    output logic [STALL_CNT_W-1:0] stall_count
);
    logic [NUM_REQ-1:0]     w_grant;
    logic                   w_any;
    logic [IDX_W-1:0]       w_winner;
    logic                   w_sel_write;
    logic [widthad_a-1:0]   w_sel_addr;
    logic [width_a-1:0]     w_sel_wdata;
    logic [width_be_a-1:0]  w_sel_be;
    logic                   w_stall;
    tag_t                   w_tag_out;
    tag_t                   r_tag [latency];
    logic [STALL_CNT_W-1:0] r_stall_count;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk      (clk),
        .reset    (reset),
        .i_req    (bus.req_valid),
        .o_grant  (w_grant),
        .o_any    (w_any),
        .o_winner (w_winner)
    );

    // Grant is one-hot, so the OR-style select yields zeros when idle
    always_comb begin
        w_sel_write = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_be    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_write = bus.req_write[i];
                w_sel_addr  = bus.req_addr[i*widthad_a +: widthad_a];
                w_sel_wdata = bus.req_wdata[i*width_a +: width_a];
                w_sel_be    = bus.req_be[i*width_be_a +: width_be_a];
            end
        end
    end

    assign bus.req_ready      = w_grant;
    assign bus.ram_clken      = ~reset;
    assign bus.ram_write_en   = w_any & w_sel_write;
    assign bus.ram_read_en    = w_any & ~w_sel_write;
    assign bus.ram_address    = w_sel_addr;
    assign bus.ram_write_data = w_sel_wdata;
    assign bus.ram_byte_en    = w_sel_be;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < latency; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0] <= '{valid: bus.ram_read_en, index: w_winner};
            for (int i = 1; i < latency; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign w_tag_out    = r_tag[latency-1];
    assign bus.rsp_data = bus.ram_read_data;

    always_comb begin
        bus.rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.rsp_valid[i] = w_tag_out.valid && !reset && (int'(w_tag_out.index) == i);
        end
    end

    assign w_stall = |(bus.req_valid & ~w_grant);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != {STALL_CNT_W{1'b1}})) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign stall_count = r_stall_count;
endmodule
`default_nettype wire

// File: tb/tb_ram_sp_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ram_sp_arbiter: directed bench with a latency-2 RAM model     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_ram_sp_arbiter;
    localparam int NR = 2;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int BW = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] stall_count;
    int          n_checks = 0;
    int          n_err = 0;

    ram_sp_arbiter_if #(.NUM_REQ(NR), .width_a(DW), .widthad_a(AW), .width_be_a(BW)) bus ();

    ram_sp_arbiter #(
        .NUM_REQ(NR), .width_a(DW), .widthad_a(AW), .width_be_a(BW), .latency(2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    // Single-port RAM, two-cycle registered read, byte-enabled write
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] r_s1, r_s2;
    always @(posedge clk) begin
        if (bus.ram_clken) begin
            if (bus.ram_write_en) begin
                for (int b = 0; b < BW; b++) begin
                    if (bus.ram_byte_en[b]) mem[bus.ram_address][8*b +: 8] <= bus.ram_write_data[8*b +: 8];
                end
            end
            r_s1 <= mem[bus.ram_address];
            r_s2 <= r_s1;
        end
    end
    assign bus.ram_read_data = r_s2;

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  write;
        logic [1:0]  exp_ready;
        logic        exp_rd;
        logic        exp_wr;
        logic [9:0]  exp_addr;
        logic [15:0] exp_stall;
    } vec_t;
    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_be    = '0;
    endtask

    task automatic drive(input int r, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [BW-1:0] be);
        bus.req_valid[r]          = 1'b1;
        bus.req_write[r]          = wr;
        bus.req_addr[r*AW +: AW]  = a;
        bus.req_wdata[r*DW +: DW] = d;
        bus.req_be[r*BW +: BW]    = be;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    initial begin
        vecs[0] = '{valid:2'b00, write:2'b00, exp_ready:2'b00, exp_rd:0, exp_wr:0, exp_addr:10'd0, exp_stall:16'd0};
        vecs[1] = '{valid:2'b11, write:2'b00, exp_ready:2'b01, exp_rd:1, exp_wr:0, exp_addr:10'd1, exp_stall:16'd0};
        vecs[2] = '{valid:2'b11, write:2'b00, exp_ready:2'b10, exp_rd:1, exp_wr:0, exp_addr:10'd2, exp_stall:16'd1};
        vecs[3] = '{valid:2'b10, write:2'b10, exp_ready:2'b10, exp_rd:0, exp_wr:1, exp_addr:10'd2, exp_stall:16'd2};
        vecs[4] = '{valid:2'b01, write:2'b01, exp_ready:2'b01, exp_rd:0, exp_wr:1, exp_addr:10'd1, exp_stall:16'd2};
        vecs[5] = '{valid:2'b01, write:2'b00, exp_ready:2'b01, exp_rd:1, exp_wr:0, exp_addr:10'd1, exp_stall:16'd2};
        vecs[6] = '{valid:2'b11, write:2'b00, exp_ready:2'b10, exp_rd:1, exp_wr:0, exp_addr:10'd2, exp_stall:16'd2};
        vecs[7] = '{valid:2'b00, write:2'b00, exp_ready:2'b00, exp_rd:0, exp_wr:0, exp_addr:10'd0, exp_stall:16'd3};

        // Reset state with requests pending
        idle();
        bus.req_valid = 2'b11;
        next_cycle();
        chk("rst_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_clken", 32'(bus.ram_clken), 32'h0);
        chk("rst_rw_en", 32'({bus.ram_read_en, bus.ram_write_en}), 32'h0);
        chk("rst_rsp", 32'(bus.rsp_valid), 32'h0);
        chk("rst_stall", 32'(stall_count), 32'h0);
        do_reset();
        #1;
        chk("post_rst_clken", 32'(bus.ram_clken), 32'h1);

        // Table-driven grant/stall sequence
        for (int i = 0; i < 8; i++) begin
            idle();
            bus.req_valid = vecs[i].valid;
            bus.req_write = vecs[i].write;
            bus.req_addr  = {10'd2, 10'd1};
            #1;
            chk($sformatf("vec%0d_ready", i), 32'(bus.req_ready), 32'(vecs[i].exp_ready));
            chk($sformatf("vec%0d_rw", i), 32'({bus.ram_read_en, bus.ram_write_en}),
                32'({vecs[i].exp_rd, vecs[i].exp_wr}));
            chk($sformatf("vec%0d_addr", i), 32'(bus.ram_address), 32'(vecs[i].exp_addr));
            chk($sformatf("vec%0d_stall", i), 32'(stall_count), 32'(vecs[i].exp_stall));
            next_cycle();
        end

        // Single read with two-cycle latency
        do_reset();
        idle(); drive(0, 1'b1, 10'd5, 32'hA5A5A5A5, 4'hF); #1;
        chk("sr_wr_ready", 32'(bus.req_ready), 32'h1);
        next_cycle();
        idle(); drive(0, 1'b0, 10'd5, 32'h0, 4'h0); #1;
        chk("sr_rd_ready", 32'(bus.req_ready), 32'h1);
        chk("sr_rd_en", 32'(bus.ram_read_en), 32'h1);
        next_cycle();
        idle(); #1;
        chk("sr_rsp_t1", 32'(bus.rsp_valid), 32'h0);
        next_cycle(); #1;
        chk("sr_rsp_t2", 32'(bus.rsp_valid), 32'h1);
        chk("sr_data", bus.rsp_data, 32'hA5A5A5A5);
        next_cycle(); #1;
        chk("sr_rsp_t3", 32'(bus.rsp_valid), 32'h0);

        // Contention: alternating grants, one stall per cycle, alternating responses
        do_reset();
        idle(); drive(1, 1'b1, 10'd1, 32'h111, 4'hF); next_cycle();
        idle(); drive(1, 1'b1, 10'd2, 32'h222, 4'hF); next_cycle();
        for (int k = 0; k < 8; k++) begin
            idle();
            if (k < 6) begin
                drive(0, 1'b0, 10'd1, 32'h0, 4'h0);
                drive(1, 1'b0, 10'd2, 32'h0, 4'h0);
            end
            #1;
            if (k < 6) begin
                chk($sformatf("ct%0d_ready", k), 32'(bus.req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
                chk($sformatf("ct%0d_stall", k), 32'(stall_count), 32'(k));
            end
            if (k >= 2) begin
                chk($sformatf("ct%0d_rsp", k), 32'(bus.rsp_valid), (k % 2 == 0) ? 32'h1 : 32'h2);
                chk($sformatf("ct%0d_data", k), bus.rsp_data, (k % 2 == 0) ? 32'h111 : 32'h222);
            end else begin
                chk($sformatf("ct%0d_rsp", k), 32'(bus.rsp_valid), 32'h0);
            end
            next_cycle();
        end

        // Byte-enabled write and write-then-read ordering
        do_reset();
        idle(); drive(1, 1'b1, 10'd7, 32'h0, 4'hF); next_cycle();
        idle(); drive(1, 1'b1, 10'd7, 32'h11223344, 4'b0101); next_cycle();
        idle(); drive(0, 1'b1, 10'd3, 32'hDEAD, 4'hF); #1;
        chk("mx_wr0_ready", 32'(bus.req_ready), 32'h1);
        next_cycle();
        idle(); drive(1, 1'b0, 10'd3, 32'h0, 4'h0); #1;
        chk("mx_rd1_ready", 32'(bus.req_ready), 32'h2);
        next_cycle();
        idle(); drive(1, 1'b0, 10'd7, 32'h0, 4'h0); #1;
        chk("mx_no_wr_rsp", 32'(bus.rsp_valid), 32'h0);
        next_cycle();
        idle(); #1;
        chk("mx_rsp_valid", 32'(bus.rsp_valid), 32'h2);
        chk("mx_rsp_data", bus.rsp_data, 32'hDEAD);
        next_cycle(); #1;
        chk("be_rsp_valid", 32'(bus.rsp_valid), 32'h2);
        chk("be_rsp_data", bus.rsp_data, 32'h00220044);
        next_cycle(); #1;
        chk("be_rsp_done", 32'(bus.rsp_valid), 32'h0);

        // Reset one cycle after a read grant discards the read
        do_reset();
        idle(); drive(0, 1'b0, 10'd5, 32'h0, 4'h0); #1;
        chk("rf_ready", 32'(bus.req_ready), 32'h1);
        next_cycle();
        idle();
        bus.req_valid = 2'b11;
        reset = 1'b1;
        #1;
        chk("rf_rst_ready", 32'(bus.req_ready), 32'h0);
        chk("rf_rst_rw", 32'({bus.ram_read_en, bus.ram_write_en}), 32'h0);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rf_rst_rsp%0d", k), 32'(bus.rsp_valid), 32'h0);
            next_cycle();
        end
        reset = 1'b0;
        idle(); drive(1, 1'b1, 10'd9, 32'h0, 4'h0); #1;
        chk("rf_req1_ready", 32'(bus.req_ready), 32'h2);
        chk("rf_stall", 32'(stall_count), 32'h0);
        next_cycle();
        idle();
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("rf_after_rsp%0d", k), 32'(bus.rsp_valid), 32'h0);
            next_cycle();
        end

        // Stall counter saturation under continuous contention
        do_reset();
        idle();
        drive(0, 1'b0, 10'd1, 32'h0, 4'h0);
        drive(1, 1'b0, 10'd2, 32'h0, 4'h0);
        for (int k = 0; k < 70000; k++) begin
            if (k == 65534) begin
                #1;
                chk("sat_pre", 32'(stall_count), 32'hFFFE);
            end
            if (k == 65535) begin
                #1;
                chk("sat_at", 32'(stall_count), 32'hFFFF);
            end
            next_cycle();
        end
        #1;
        chk("sat_hold", 32'(stall_count), 32'hFFFF);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
`default_nettype wire
